rpn_stack_engine: RTL
=====================

// Module: rpn_stack_engine
// PURPOSE
//  Parametrised RPN stack/ALU engine. Next generation of the single-width calculator datapath.
//  Accepts PUSH/POP/OP/CLEAR commands over a valid/ready handshake.
//  Keeps a DEPTH-entry stack in synchronous-read memory and detects overflow/underflow.
//  Sits between the board I/O front end (keys/switches/HEX) and the display decode logic.
// PARAMETERS
//  WIDTH  8   data width of stack entries, operands and result
//  DEPTH  16  stack entries; power of two, >=4; AW = $clog2(DEPTH)
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst_n      in   1        asynchronous active-low reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        engine can accept command (high only in IDLE)
//  cmd_op     in   2        0 PUSH, 1 POP, 2 OP, 3 CLEAR
//  alu_sel    in   3        ALU op for OP: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 MUL 6 SHL 7 SHR
//  cmd_data   in   WIDTH    operand for PUSH
//  done       out  1        one-cycle pulse: command retired (success or error)
//  tos        out  WIDTH    current top of stack; 0 when empty
//  count      out  AW+1     entries on stack, 0..DEPTH
//  carry      out  1        ADD carry-out / SUB borrow of last OP; 0 for other ops
//  err        out  1        sticky error flag
//  err_code   out  2        0 none, 1 overflow, 2 underflow
//  clr_err    in   1        clears a sticky error and returns the engine to IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; count=0; state IDLE. Memory contents are don't-care.
//   Reset is honoured in any state and aborts an in-flight OP with no writeback.
//  Handshake: a command is accepted when cmd_valid&&cmd_ready. Inputs are sampled only then.
//   cmd_ready drops the cycle after acceptance.
//  States: IDLE, PUSH_WR, POP_RD, RD_B, RD_A, EXEC, ERROR.
//  PUSH: if count==DEPTH -> ERROR with code 1 and the stack unchanged.
//   Else write mem[count], set tos=cmd_data, count+1, done in the cycle after acceptance.
//  POP: if count==0 -> ERROR with code 2.
//   Else count-1 and read mem[count-2] (1-cycle latency) to refresh tos.
//   tos=0 if the new count is 0. done 2 cycles after acceptance.
//  OP: if count<2 -> ERROR with code 2 and the stack unchanged.
//   Else B=tos (register), A read from mem[count-2].
//   EXEC writes the result to mem[count-2], sets tos=result, count-1.
//   done 3 cycles after acceptance. Results are wrapped modulo 2^WIDTH.
//   SUB = A-B. MUL keeps the low WIDTH bits.
//   SHL/SHR shift A by B[$clog2(WIDTH)-1:0] with zero fill.
//  CLEAR: count=0, tos=0, carry=0, done in the next cycle. Legal in IDLE only.
//  ERROR: err=1, cmd_ready=0, done pulses once on entry. Stack, count and tos are held.
//   clr_err=1 -> IDLE and err/err_code=0 next cycle. clr_err in non-ERROR states is ignored.
//  Read/write to the same address in one cycle must not occur by construction.
//   Only EXEC and PUSH_WR write.
//  Commands arriving while not ready are held by the source; none are dropped or queued.
// STRUCTURE
//  rpn_pkg holds:
//   typedef enum cmd_e {CMD_PUSH, CMD_POP, CMD_OP, CMD_CLEAR}
//   typedef enum alu_e (8 ops)
//   typedef enum err_e {ERR_NONE, ERR_OVF, ERR_UNF}
//   the state enum
//  Sub-module: rpn_alu #(WIDTH) — combinational, inputs a/b/sel, outputs result/carry.
//  Stack memory is an inferred synchronous-read array inside rpn_stack_engine.
// TESTING
//  1. Basic OP: PUSH 5, PUSH 3, OP ADD -> tos=8, count=1, carry=0. done 3 cycles after OP accept.
//  2. Operand order/flags:
//   PUSH 3, PUSH 5, OP SUB -> tos=8'hFE, carry=1.
//   PUSH 200, PUSH 100, OP ADD -> tos=44, carry=1.
//  3. Overflow: DEPTH=16. 16 PUSHes then a 17th -> err=1, err_code=1, count=16, tos unchanged.
//   clr_err -> IDLE, and a POP then returns the 15th value.
//  4. Underflow: empty POP -> err_code=2. Single entry then OP AND -> err_code=2, count=1.
//  5. Shifts/MUL, WIDTH=8:
//   PUSH 8'h81, PUSH 9, OP SHL -> 8'h02.
//   PUSH 20, PUSH 13, OP MUL -> 8'h04.
//  6. rst_n asserted during RD_A of an OP -> count=0, tos=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack engine: command, ALU, error and FSM state encodings.
package rpn_pkg;

   typedef enum logic [1:0] {
      CMD_PUSH  = 2'd0,
      CMD_POP   = 2'd1,
      CMD_OP    = 2'd2,
      CMD_CLEAR = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_MUL = 3'd5,
      ALU_SHL = 3'd6,
      ALU_SHR = 3'd7
   } alu_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_OVF  = 2'd1,
      ERR_UNF  = 2'd2
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PUSH_WR = 3'd1,
      ST_POP_RD  = 3'd2,
      ST_RD_B    = 3'd3,
      ST_RD_A    = 3'd4,
      ST_EXEC    = 3'd5,
      ST_ERROR   = 3'd6
   } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN engine. Results wrap modulo 2^WIDTH;
// carry reports ADD carry-out or SUB borrow and is 0 for every other op.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_e             sel,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH:0]  wide_s;
   logic [SW-1:0]   shamt_s;

   // Operation select; shifts use only the low log2(WIDTH) bits of b.
   always_comb begin
      wide_s  = '0;
      result  = '0;
      carry   = 1'b0;
      shamt_s = b[SW-1:0];
      case (sel)
         ALU_ADD: begin
            wide_s = {1'b0, a} + {1'b0, b};
            result = wide_s[WIDTH-1:0];
            carry  = wide_s[WIDTH];
         end
         ALU_SUB: begin
            wide_s = {1'b0, a} - {1'b0, b};
            result = wide_s[WIDTH-1:0];
            carry  = wide_s[WIDTH];
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_MUL: result = a * b;
         ALU_SHL: result = a << shamt_s;
         ALU_SHR: result = a >> shamt_s;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN stack/ALU engine: valid/ready command port, DEPTH-entry synchronous-read
// stack memory, overflow/underflow detection with a sticky error state.
module rpn_stack_engine
   import rpn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             done,
   output logic [WIDTH-1:0] tos,
   output logic [AW:0]      count,
   output logic             carry,
   output logic             err,
   output logic [1:0]       err_code,
   input  logic             clr_err
);

   state_e           state_q;
   logic [AW:0]      count_q;
   logic [WIDTH-1:0] tos_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] data_q;
   alu_e             alu_sel_q;
   logic             pop_ph_q;
   logic             ready_q;
   logic             done_q;
   logic             carry_q;
   logic             err_q;
   err_e             err_code_q;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   logic             accept_s;
   logic             rd_en_s;
   logic             wr_en_s;
   logic [AW-1:0]    rd_addr_s;
   logic [AW-1:0]    wr_addr_s;
   logic [WIDTH-1:0] wr_data_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_carry_s;

   rpn_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (a_q),
      .b      (b_q),
      .sel    (alu_sel_q),
      .result (alu_res_s),
      .carry  (alu_carry_s)
   );

   assign accept_s = cmd_valid && ready_q;

   // Memory port control: the read and write phases never overlap, so the
   // next-to-top address is never read and written in the same cycle.
   always_comb begin
      rd_en_s   = 1'b0;
      wr_en_s   = 1'b0;
      rd_addr_s = count_q[AW-1:0] - AW'(2);
      wr_addr_s = count_q[AW-1:0] - AW'(2);
      wr_data_s = alu_res_s;
      if (state_q == ST_PUSH_WR) begin
         wr_en_s   = 1'b1;
         wr_addr_s = count_q[AW-1:0];
         wr_data_s = data_q;
      end else if (state_q == ST_EXEC) begin
         wr_en_s = 1'b1;
      end else if ((state_q == ST_RD_B) || ((state_q == ST_POP_RD) && !pop_ph_q)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   // Stack storage; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_addr_s] <= wr_data_s;
      end
      if (rd_en_s) begin
         rd_data_q <= mem_q[rd_addr_s];
      end
   end

   // Control FSM with all externally visible state registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         tos_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         data_q     <= '0;
         alu_sel_q  <= ALU_ADD;
         pop_ph_q   <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  ready_q <= 1'b0;
                  case (cmd_e'(cmd_op))
                     CMD_PUSH: begin
                        if (count_q == (AW+1)'(DEPTH)) begin
                           state_q    <= ST_ERROR;
                           err_q      <= 1'b1;
                           err_code_q <= ERR_OVF;
                           done_q     <= 1'b1;
                        end else begin
                           data_q  <= cmd_data;
                           state_q <= ST_PUSH_WR;
                        end
                     end
                     CMD_POP: begin
                        if (count_q == (AW+1)'(0)) begin
                           state_q    <= ST_ERROR;
                           err_q      <= 1'b1;
                           err_code_q <= ERR_UNF;
                           done_q     <= 1'b1;
                        end else begin
                           pop_ph_q <= 1'b0;
                           state_q  <= ST_POP_RD;
                        end
                     end
                     CMD_OP: begin
                        if (count_q < (AW+1)'(2)) begin
                           state_q    <= ST_ERROR;
                           err_q      <= 1'b1;
                           err_code_q <= ERR_UNF;
                           done_q     <= 1'b1;
                        end else begin
                           b_q       <= tos_q;
                           alu_sel_q <= alu_e'(alu_sel);
                           state_q   <= ST_RD_B;
                        end
                     end
                     CMD_CLEAR: begin
                        count_q <= '0;
                        tos_q   <= '0;
                        carry_q <= 1'b0;
                        done_q  <= 1'b1;
                     end
                     default: state_q <= ST_IDLE;
                  endcase
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_PUSH_WR: begin
               tos_q   <= data_q;
               count_q <= count_q + (AW+1)'(1);
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            ST_POP_RD: begin
               // First cycle issues the read; second consumes the registered data.
               if (!pop_ph_q) begin
                  pop_ph_q <= 1'b1;
               end else begin
                  count_q <= count_q - (AW+1)'(1);
                  tos_q   <= (count_q == (AW+1)'(1)) ? '0 : rd_data_q;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_RD_B: state_q <= ST_RD_A;
            ST_RD_A: begin
               a_q     <= rd_data_q;
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               tos_q   <= alu_res_s;
               carry_q <= alu_carry_s;
               count_q <= count_q - (AW+1)'(1);
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            ST_ERROR: begin
               if (clr_err) begin
                  err_q      <= 1'b0;
                  err_code_q <= ERR_NONE;
                  ready_q    <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  ready_q <= 1'b0;
               end
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = ready_q;
   assign done      = done_q;
   assign tos       = tos_q;
   assign count     = count_q;
   assign carry     = carry_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule
